// File: rtl/song_sequencer.sv
// song_sequencer: steps through a fixed song table held in a case-ROM and
// drives the buzzer driver with a per-note clock divider plus a mute flag.
// Each note is followed by a short muted articulation gap. Playback is
// controlled by start/stop, and progress is reported on busy/done/note_idx.
//
// Build option: define SEQ_LOOP_EN to repeat the song indefinitely. After
// each pass, done still pulses and playback restarts at entry 0 with busy
// held high. Without the macro the song plays once and returns to idle.
module song_sequencer #(
    parameter int unsigned CLK_FREQ    = 50_000_000,
    parameter int unsigned BEAT_CYCLES = 12_500_000,
    parameter int unsigned GAP_CYCLES  = 500_000,
    parameter int unsigned SONG_LEN    = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        stop,
    output logic [31:0] div,
    output logic        mute,
    output logic        busy,
    output logic [4:0]  note_idx,
    output logic        done
);

    localparam int unsigned    IDX_W     = (SONG_LEN > 1) ? $clog2(SONG_LEN) : 1;
    localparam logic [4:0]     NOTE_END  = 5'd31;
    localparam logic [4:0]     NOTE_LAST = 5'd21;
    localparam logic [31:0]    BEAT_LAST = 32'(BEAT_CYCLES - 1);
    localparam logic [31:0]    GAP_LAST  = 32'(GAP_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SONG_LEN - 1);

    typedef enum logic [2:0] {IDLE, LOAD, PLAY, GAP, FIN} state_t;

    // Note frequencies in Hz: codes 1..21 are the naturals C4..B6.
    function automatic int unsigned note_freq(input int unsigned code);
        int unsigned f;
        case (code)
            1:  f = 262;   2:  f = 294;   3:  f = 330;   4:  f = 349;
            5:  f = 392;   6:  f = 440;   7:  f = 494;
            8:  f = 523;   9:  f = 587;   10: f = 659;   11: f = 698;
            12: f = 784;   13: f = 880;   14: f = 988;
            15: f = 1047;  16: f = 1175;  17: f = 1319;  18: f = 1397;
            19: f = 1568;  20: f = 1760;  21: f = 1976;
            default: f = 0;
        endcase
        return f;
    endfunction

    // Divider for one note code; rests and unused codes map to 0.
    function automatic logic [31:0] note_div(input int unsigned code);
        int unsigned f;
        f = note_freq(code);
        return (f == 0) ? 32'd0 : 32'(CLK_FREQ / f);
    endfunction

    // Song table: {note[4:0], beats[2:0]}. Everything past the song reads
    // as the end marker, so the table can be shorter than SONG_LEN.
    function automatic logic [7:0] song_rom(input logic [4:0] addr);
        logic [7:0] entry;
        case (addr)
            5'd0:    entry = {5'd1, 3'd2};   // C4, 2 beats
            5'd1:    entry = {5'd0, 3'd1};   // rest, 1 beat
            5'd2:    entry = {5'd6, 3'd1};   // A4, 1 beat
            default: entry = {NOTE_END, 3'd0};
        endcase
        return entry;
    endfunction

    // Divider LUT, fully constant after elaboration.
    logic [31:0] div_lut [0:31];
    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_div_lut
            assign div_lut[gi] = note_div(gi);
        end
    endgenerate

    state_t          state_reg, state_next;
    logic [31:0]     div_reg,   div_next;
    logic            mute_reg,  mute_next;
    logic            busy_reg,  busy_next;
    logic            done_reg,  done_next;
    logic [IDX_W-1:0] idx_reg,  idx_next;
    logic [31:0]     cnt_reg,   cnt_next;
    logic [2:0]      beat_reg,  beat_next;

    logic [7:0]      rom_data;
    logic [4:0]      rom_note;
    logic [2:0]      rom_beats;
    logic            rom_rest;
    logic            fin_entry;

    // Current table entry and its decoded fields.
    always_comb begin
        rom_data  = song_rom(5'(idx_reg));
        rom_note  = rom_data[7:3];
        rom_beats = rom_data[2:0];
        rom_rest  = (rom_note == 5'd0) || (rom_note > NOTE_LAST);
    end

    // Next-state and next-output logic; stop overrides everything outside IDLE.
    always_comb begin
        state_next = state_reg;
        div_next   = div_reg;
        mute_next  = mute_reg;
        busy_next  = busy_reg;
        done_next  = 1'b0;
        idx_next   = idx_reg;
        cnt_next   = cnt_reg;
        beat_next  = beat_reg;
        fin_entry  = 1'b0;

        case (state_reg)
            IDLE: begin
                if (start && !stop) begin
                    state_next = LOAD;
                    busy_next  = 1'b1;
                end
            end
            LOAD: begin
                if (rom_note == NOTE_END) begin
                    fin_entry = 1'b1;
                end else begin
                    div_next   = rom_rest ? 32'd0 : div_lut[rom_note];
                    mute_next  = rom_rest;
                    beat_next  = (rom_beats == 3'd0) ? 3'd1 : rom_beats;
                    cnt_next   = 32'd0;
                    state_next = PLAY;
                end
            end
            PLAY: begin
                if (cnt_reg == BEAT_LAST) begin
                    cnt_next = 32'd0;
                    if (beat_reg <= 3'd1) begin
                        state_next = GAP;
                        mute_next  = 1'b1;
                    end else begin
                        beat_next = beat_reg - 3'd1;
                    end
                end else begin
                    cnt_next = cnt_reg + 32'd1;
                end
            end
            GAP: begin
                if (cnt_reg == GAP_LAST) begin
                    cnt_next = 32'd0;
                    if (idx_reg == IDX_LAST) begin
                        fin_entry = 1'b1;
                    end else begin
                        idx_next   = idx_reg + 1'b1;
                        state_next = LOAD;
                    end
                end else begin
                    cnt_next = cnt_reg + 32'd1;
                end
            end
            FIN: begin
`ifdef SEQ_LOOP_EN
                state_next = LOAD;
`else
                state_next = IDLE;
`endif
            end
            default: state_next = IDLE;
        endcase

        // Entering FIN: silence the buzzer, rewind, and pulse done.
        if (fin_entry) begin
            state_next = FIN;
            div_next   = 32'd0;
            mute_next  = 1'b1;
            done_next  = 1'b1;
            idx_next   = '0;
            cnt_next   = 32'd0;
`ifdef SEQ_LOOP_EN
            busy_next  = 1'b1;
`else
            busy_next  = 1'b0;
`endif
        end

        // Abort: back to idle values without a done pulse.
        if (stop && (state_reg != IDLE)) begin
            state_next = IDLE;
            div_next   = 32'd0;
            mute_next  = 1'b1;
            busy_next  = 1'b0;
            done_next  = 1'b0;
            idx_next   = '0;
            cnt_next   = 32'd0;
            beat_next  = 3'd0;
        end
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            div_reg   <= 32'd0;
            mute_reg  <= 1'b1;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            idx_reg   <= '0;
            cnt_reg   <= 32'd0;
            beat_reg  <= 3'd0;
        end else begin
            state_reg <= state_next;
            div_reg   <= div_next;
            mute_reg  <= mute_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
            idx_reg   <= idx_next;
            cnt_reg   <= cnt_next;
            beat_reg  <= beat_next;
        end
    end

    assign div      = div_reg;
    assign mute     = mute_reg;
    assign busy     = busy_reg;
    assign done     = done_reg;
    assign note_idx = 5'(idx_reg);

endmodule

// File: tb/tb_song_sequencer.sv
// Testbench for song_sequencer: a table of timed segments covering a full
// playback pass, then hand-written sequences for asynchronous reset,
// stop, and start/stop collisions.
module tb_song_sequencer;

    localparam int unsigned CF = 1_000_000;
    localparam int unsigned BC = 10;
    localparam int unsigned GC = 2;
    localparam int unsigned SL = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [31:0] div;
    logic        mute;
    logic        busy;
    logic [4:0]  note_idx;
    logic        done;

    int n_cmp  = 0;
    int n_fail = 0;

    song_sequencer #(
        .CLK_FREQ(CF),
        .BEAT_CYCLES(BC),
        .GAP_CYCLES(GC),
        .SONG_LEN(SL)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .stop(stop),
        .div(div),
        .mute(mute),
        .busy(busy),
        .note_idx(note_idx),
        .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cycles;
        logic        start;
        logic        stop;
        logic [31:0] div;
        logic        mute;
        logic        busy;
        logic        done;
        logic [4:0]  idx;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input int n, input logic s, input logic p,
                           input logic [31:0] d, input logic m, input logic b,
                           input logic dn, input logic [4:0] i);
        vec_t v;
        v.cycles = n; v.start = s; v.stop = p;
        v.div = d; v.mute = m; v.busy = b; v.done = dn; v.idx = i;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] e_div,
                         input logic e_mute, input logic e_busy,
                         input logic e_done, input logic [4:0] e_idx);
        n_cmp++;
        if (div !== e_div || mute !== e_mute || busy !== e_busy ||
            done !== e_done || note_idx !== e_idx) begin
            n_fail++;
            $display("FAIL %s: got div=%0d mute=%b busy=%b done=%b idx=%0d, expected div=%0d mute=%b busy=%b done=%b idx=%0d",
                     name, div, mute, busy, done, note_idx,
                     e_div, e_mute, e_busy, e_done, e_idx);
        end
    endtask

    // Advance one clock and sample 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Full pass: LOAD, C4 x2 beats (with ignored start pulses), rest, A4, end.
        add_vec(1,  1'b1, 1'b0, 32'd0,    1'b1, 1'b1, 1'b0, 5'd0);
        add_vec(5,  1'b0, 1'b0, 32'd3816, 1'b0, 1'b1, 1'b0, 5'd0);
        add_vec(1,  1'b1, 1'b0, 32'd3816, 1'b0, 1'b1, 1'b0, 5'd0);
        add_vec(14, 1'b0, 1'b0, 32'd3816, 1'b0, 1'b1, 1'b0, 5'd0);
        add_vec(1,  1'b1, 1'b0, 32'd3816, 1'b1, 1'b1, 1'b0, 5'd0);
        add_vec(1,  1'b0, 1'b0, 32'd3816, 1'b1, 1'b1, 1'b0, 5'd0);
        add_vec(1,  1'b0, 1'b0, 32'd3816, 1'b1, 1'b1, 1'b0, 5'd1);
        add_vec(12, 1'b0, 1'b0, 32'd0,    1'b1, 1'b1, 1'b0, 5'd1);
        add_vec(1,  1'b0, 1'b0, 32'd0,    1'b1, 1'b1, 1'b0, 5'd2);
        add_vec(10, 1'b0, 1'b0, 32'd2272, 1'b0, 1'b1, 1'b0, 5'd2);
        add_vec(2,  1'b0, 1'b0, 32'd2272, 1'b1, 1'b1, 1'b0, 5'd2);
        add_vec(1,  1'b0, 1'b0, 32'd2272, 1'b1, 1'b1, 1'b0, 5'd3);
`ifdef SEQ_LOOP_EN
        add_vec(1,  1'b0, 1'b0, 32'd0,    1'b1, 1'b1, 1'b1, 5'd0);
        add_vec(1,  1'b0, 1'b0, 32'd0,    1'b1, 1'b1, 1'b0, 5'd0);
        add_vec(3,  1'b0, 1'b0, 32'd3816, 1'b0, 1'b1, 1'b0, 5'd0);
        add_vec(1,  1'b0, 1'b1, 32'd0,    1'b1, 1'b0, 1'b0, 5'd0);
`else
        add_vec(1,  1'b0, 1'b0, 32'd0,    1'b1, 1'b0, 1'b1, 5'd0);
        add_vec(3,  1'b0, 1'b0, 32'd0,    1'b1, 1'b0, 1'b0, 5'd0);
`endif

        // Reset held, then released between edges.
        repeat (3) @(posedge clk);
        #1;
        check("reset_hold", 32'd0, 1'b1, 1'b0, 1'b0, 5'd0);
        #2 rst = 1'b0;
        tick();
        check("idle_after_reset", 32'd0, 1'b1, 1'b0, 1'b0, 5'd0);

        // Table-driven playback pass.
        for (int r = 0; r < vecs.size(); r++) begin
            for (int c = 0; c < vecs[r].cycles; c++) begin
                start = vecs[r].start;
                stop  = vecs[r].stop;
                tick();
                start = 1'b0;
                stop  = 1'b0;
                check($sformatf("vec%0d_cyc%0d", r, c), vecs[r].div,
                      vecs[r].mute, vecs[r].busy, vecs[r].done, vecs[r].idx);
            end
            $display("vec %0d: %0d cycle(s), expected div=%0d mute=%b busy=%b done=%b idx=%0d",
                     r, vecs[r].cycles, vecs[r].div, vecs[r].mute,
                     vecs[r].busy, vecs[r].done, vecs[r].idx);
        end

        // Asynchronous reset in the middle of C4.
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        check("pre_reset_play", 32'd3816, 1'b0, 1'b1, 1'b0, 5'd0);
        #3 rst = 1'b1;
        #1;
        check("async_reset_same_instant", 32'd0, 1'b1, 1'b0, 1'b0, 5'd0);
        #2 rst = 1'b0;
        tick();
        check("idle_after_async_reset", 32'd0, 1'b1, 1'b0, 1'b0, 5'd0);
        $display("async reset mid-play applied");

        // Stop five cycles into C4, then confirm done never pulses.
        begin
            int done_seen;
            start = 1'b1;
            tick();
            start = 1'b0;
            repeat (5) tick();
            check("c4_before_stop", 32'd3816, 1'b0, 1'b1, 1'b0, 5'd0);
            stop = 1'b1;
            tick();
            stop = 1'b0;
            check("stop_to_idle", 32'd0, 1'b1, 1'b0, 1'b0, 5'd0);
            done_seen = 0;
            for (int k = 0; k < 60; k++) begin
                tick();
                if (done === 1'b1 || busy === 1'b1) done_seen++;
            end
            n_cmp++;
            if (done_seen != 0) begin
                n_fail++;
                $display("FAIL stop_no_done: saw done/busy high on %0d cycles, expected 0", done_seen);
            end
            $display("stop during C4 applied");
        end

        // Restart after stop begins again at entry 0.
        start = 1'b1;
        tick();
        start = 1'b0;
        check("restart_load", 32'd0, 1'b1, 1'b1, 1'b0, 5'd0);
        tick();
        check("restart_c4", 32'd3816, 1'b0, 1'b1, 1'b0, 5'd0);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("restart_stop", 32'd0, 1'b1, 1'b0, 1'b0, 5'd0);
        $display("restart after stop applied");

        // start and stop together from IDLE: stays idle.
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        check("start_stop_idle", 32'd0, 1'b1, 1'b0, 1'b0, 5'd0);
        tick();
        check("start_stop_idle_hold", 32'd0, 1'b1, 1'b0, 1'b0, 5'd0);
        $display("start+stop from idle applied");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
